// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch opcode encodings, default reset/exception
// addresses and the branch condition evaluator used by the fetch unit.
package cpu_pkg;

    localparam int unsigned PC_W_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_4180;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BEQ  = 3'd1,
        BR_BNE  = 3'd2,
        BR_BLEZ = 3'd3,
        BR_BGTZ = 3'd4,
        BR_BLTZ = 3'd5,
        BR_BGEZ = 3'd6,
        BR_RSVD = 3'd7
    } br_op_e;

    // Signed compare outcome from precomputed equality/sign/zero flags.
    function automatic logic br_taken(input br_op_e op, input logic is_eq,
                                      input logic is_neg, input logic is_zero);
        logic t;
        t = 1'b0;
        case (op)
            BR_BEQ:  t = is_eq;
            BR_BNE:  t = !is_eq;
            BR_BLEZ: t = is_neg || is_zero;
            BR_BGTZ: t = !is_neg && !is_zero;
            BR_BLTZ: t = is_neg;
            BR_BGEZ: t = !is_neg;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/pc_unit_tgt.sv
// Branch resolution and control-transfer target selection for the fetch unit.
// Purely combinational; the caller owns all PC state.
module pc_unit_tgt
    import cpu_pkg::*;
#(
    parameter int unsigned     PC_W    = PC_W_DEF,
    parameter logic [PC_W-1:0] EXC_VEC = PC_W'(EXC_VEC_DEF)
) (
    input  logic            stall,
    input  logic [PC_W-1:0] d_pc,
    input  logic [2:0]      br_op,
    input  logic [PC_W-1:0] rs_val,
    input  logic [PC_W-1:0] rt_val,
    input  logic [15:0]     imm16,
    input  logic [25:0]     imm26,
    input  logic            j_sign,
    input  logic            jr_sign,
    input  logic            exc_req,
    input  logic            eret_req,
    input  logic [PC_W-1:0] epc,
    output logic [PC_W-1:0] target_c,
    output logic            d_redirect_c
);

    logic            taken;
    logic [PC_W-1:0] imm_sx;
    logic [PC_W-1:0] br_tgt;
    logic [PC_W-1:0] j_tgt;

    always_comb begin
        taken  = br_taken(br_op_e'(br_op), rs_val == rt_val,
                          rs_val[PC_W-1], rs_val == '0);
        imm_sx = {{(PC_W-16){imm16[15]}}, imm16};
        br_tgt = d_pc + PC_W'(4) + (imm_sx << 2);
        j_tgt  = {d_pc[PC_W-1:28], imm26, 2'b00};

        // Priority chain, highest first.
        target_c = br_tgt;
        if (exc_req)       target_c = EXC_VEC;
        else if (eret_req) target_c = epc;
        else if (taken)    target_c = br_tgt;
        else if (j_sign)   target_c = j_tgt;
        else if (jr_sign)  target_c = rs_val;

        // D recomputes next cycle while stalled, so its transfers wait.
        d_redirect_c = !stall && (eret_req || taken || j_sign || jr_sign);
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch PC register with a one-entry pending-redirect latch that holds a
// control transfer until instruction memory accepts it.
module pc_unit
    import cpu_pkg::*;
#(
    parameter int unsigned     PC_W     = PC_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF),
    parameter logic [PC_W-1:0] EXC_VEC  = PC_W'(EXC_VEC_DEF)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            imem_ready,
    input  logic [PC_W-1:0] D_PC,
    input  logic [2:0]      br_op,
    input  logic [PC_W-1:0] rs_val,
    input  logic [PC_W-1:0] rt_val,
    input  logic [15:0]     imm16,
    input  logic [25:0]     imm26,
    input  logic            j_sign,
    input  logic            jr_sign,
    input  logic            exc_req,
    input  logic            eret_req,
    input  logic [PC_W-1:0] epc,
    output logic [PC_W-1:0] F_PC,
    output logic [PC_W-1:0] D_PC8,
    output logic            redirect,
    output logic            pend_valid
);

    logic [PC_W-1:0] target_c;
    logic            d_redirect_c;
    logic [PC_W-1:0] pend;

    pc_unit_tgt #(
        .PC_W    (PC_W),
        .EXC_VEC (EXC_VEC)
    ) u_tgt (
        .stall        (stall),
        .d_pc         (D_PC),
        .br_op        (br_op),
        .rs_val       (rs_val),
        .rt_val       (rt_val),
        .imm16        (imm16),
        .imm26        (imm26),
        .j_sign       (j_sign),
        .jr_sign      (jr_sign),
        .exc_req      (exc_req),
        .eret_req     (eret_req),
        .epc          (epc),
        .target_c     (target_c),
        .d_redirect_c (d_redirect_c)
    );

    assign redirect = !reset && (exc_req || d_redirect_c);
    assign D_PC8    = D_PC + PC_W'(8);

    // Exceptions beat the pended transfer, which in turn beats newer D redirects.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            F_PC       <= RESET_PC;
            pend       <= '0;
            pend_valid <= 1'b0;
        end else if (exc_req || (d_redirect_c && !pend_valid)) begin
            if (imem_ready) begin
                F_PC       <= target_c;
                pend_valid <= 1'b0;
            end else begin
                pend       <= target_c;
                pend_valid <= 1'b1;
            end
        end else if (pend_valid) begin
            if (imem_ready) begin
                F_PC       <= pend;
                pend_valid <= 1'b0;
            end
        end else if (!stall && imem_ready) begin
            F_PC <= F_PC + PC_W'(4);
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: single-cycle vector table plus hand-written
// sequences for pending redirects, exceptions and asynchronous reset.
module tb_pc_unit;

    localparam logic [1:0] M_ABS = 2'd0;
    localparam logic [1:0] M_INC = 2'd1;
    localparam logic [1:0] M_HLD = 2'd2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall, imem_ready, j_sign, jr_sign, exc_req, eret_req;
    logic [31:0] D_PC, rs_val, rt_val, epc;
    logic [2:0]  br_op;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] F_PC, D_PC8;
    logic        redirect, pend_valid;

    int total = 0;
    int bad   = 0;
    logic [31:0] model;

    pc_unit dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .imem_ready (imem_ready),
        .D_PC       (D_PC),
        .br_op      (br_op),
        .rs_val     (rs_val),
        .rt_val     (rt_val),
        .imm16      (imm16),
        .imm26      (imm26),
        .j_sign     (j_sign),
        .jr_sign    (jr_sign),
        .exc_req    (exc_req),
        .eret_req   (eret_req),
        .epc        (epc),
        .F_PC       (F_PC),
        .D_PC8      (D_PC8),
        .redirect   (redirect),
        .pend_valid (pend_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] dpc, rs, rt;
        logic [15:0] i16;
        logic [25:0] i26;
        logic        j, jr, exc, eret;
        logic [31:0] epc;
        logic        stall, rdy, red;
        logic [1:0]  mode;
        logic [31:0] nxt;
    } vec_t;

    function automatic vec_t mk(input logic [2:0] op, input logic [31:0] dpc,
                                input logic [31:0] rs, input logic [31:0] rt,
                                input logic [15:0] i16, input logic [25:0] i26,
                                input logic j, input logic jr, input logic exc,
                                input logic eret, input logic [31:0] ep,
                                input logic st, input logic rdy, input logic red,
                                input logic [1:0] mode, input logic [31:0] nxt);
        vec_t v;
        v.op = op; v.dpc = dpc; v.rs = rs; v.rt = rt; v.i16 = i16; v.i26 = i26;
        v.j = j; v.jr = jr; v.exc = exc; v.eret = eret; v.epc = ep;
        v.stall = st; v.rdy = rdy; v.red = red; v.mode = mode; v.nxt = nxt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        stall = 1'b0; imem_ready = 1'b1; D_PC = 32'h3004; br_op = 3'd0;
        rs_val = '0; rt_val = '0; imm16 = '0; imm26 = '0;
        j_sign = 1'b0; jr_sign = 1'b0; exc_req = 1'b0; eret_req = 1'b0; epc = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t vt[$];

    initial begin
        logic [31:0] exp;
        idle();

        // Power-up reset, with an exception request that must not redirect.
        exc_req = 1'b1;
        #2 reset = 1'b1;
        #1;
        chk("reset F_PC", F_PC, 32'h3000);
        chk("reset pend_valid", 32'(pend_valid), 0);
        chk("reset redirect", 32'(redirect), 0);
        step();
        @(negedge clk);
        reset = 1'b0;
        exc_req = 1'b0;
        #1;
        chk("rel F_PC0", F_PC, 32'h3000);
        step();
        chk("rel F_PC1", F_PC, 32'h3004);
        step();
        chk("rel F_PC2", F_PC, 32'h3008);
        model = 32'h3008;

        //          op  dpc            rs             rt     i16       i26        j  jr exc eret epc           st rdy red mode   nxt
        vt.push_back(mk(0, 32'h3004,     0,             0,     16'h0,    26'h0,     0, 0, 0, 0, 0,             0, 1, 0, M_INC, 0));
        vt.push_back(mk(1, 32'h3004,     5,             5,     16'hFFFF, 26'h0,     0, 0, 0, 0, 0,             0, 1, 1, M_ABS, 32'h3004));
        vt.push_back(mk(1, 32'h3004,     5,             6,     16'hFFFF, 26'h0,     0, 0, 0, 0, 0,             0, 1, 0, M_INC, 0));
        vt.push_back(mk(2, 32'h3004,     1,             2,     16'h0010, 26'h0,     0, 0, 0, 0, 0,             0, 1, 1, M_ABS, 32'h3048));
        vt.push_back(mk(3, 32'h3100,     32'h80000000,  0,     16'h0004, 26'h0,     0, 0, 0, 0, 0,             0, 1, 1, M_ABS, 32'h3114));
        vt.push_back(mk(3, 32'h3100,     1,             0,     16'h0004, 26'h0,     0, 0, 0, 0, 0,             0, 1, 0, M_INC, 0));
        vt.push_back(mk(3, 32'h3200,     0,             0,     16'h0,    26'h0,     0, 0, 0, 0, 0,             0, 1, 1, M_ABS, 32'h3204));
        vt.push_back(mk(4, 32'h3000,     1,             0,     16'h0008, 26'h0,     0, 0, 0, 0, 0,             0, 1, 1, M_ABS, 32'h3024));
        vt.push_back(mk(4, 32'h3000,     0,             0,     16'h0008, 26'h0,     0, 0, 0, 0, 0,             0, 1, 0, M_INC, 0));
        vt.push_back(mk(5, 32'h3010,     32'hFFFFFFFF,  0,     16'hFFFE, 26'h0,     0, 0, 0, 0, 0,             0, 1, 1, M_ABS, 32'h300C));
        vt.push_back(mk(5, 32'h3010,     0,             0,     16'hFFFE, 26'h0,     0, 0, 0, 0, 0,             0, 1, 0, M_INC, 0));
        vt.push_back(mk(6, 32'h3010,     0,             0,     16'h0001, 26'h0,     0, 0, 0, 0, 0,             0, 1, 1, M_ABS, 32'h3018));
        vt.push_back(mk(6, 32'h3010,     32'h80000000,  0,     16'h0001, 26'h0,     0, 0, 0, 0, 0,             0, 1, 0, M_INC, 0));
        vt.push_back(mk(7, 32'h3004,     5,             5,     16'h0010, 26'h0,     0, 0, 0, 0, 0,             0, 1, 0, M_INC, 0));
        vt.push_back(mk(0, 32'hF0000000, 0,             0,     16'h0,    26'h0C40,  1, 0, 0, 0, 0,             0, 1, 1, M_ABS, 32'hF0003100));
        vt.push_back(mk(0, 32'h3004,     32'h5550,      0,     16'h0,    26'h0,     0, 1, 0, 0, 0,             0, 1, 1, M_ABS, 32'h5550));
        vt.push_back(mk(0, 32'h3004,     0,             0,     16'h0,    26'h0,     0, 0, 0, 1, 32'h3010,      0, 1, 1, M_ABS, 32'h3010));
        vt.push_back(mk(0, 32'h3004,     0,             0,     16'h0,    26'h0,     0, 0, 1, 0, 0,             0, 1, 1, M_ABS, 32'h4180));
        vt.push_back(mk(0, 32'h3004,     0,             0,     16'h0,    26'h0,     0, 0, 1, 0, 0,             1, 1, 1, M_ABS, 32'h4180));
        vt.push_back(mk(0, 32'h3004,     0,             0,     16'h0,    26'h0C40,  1, 0, 0, 0, 0,             1, 1, 0, M_HLD, 0));
        vt.push_back(mk(1, 32'h3004,     5,             5,     16'hFFFF, 26'h0,     0, 0, 0, 0, 0,             1, 1, 0, M_HLD, 0));
        vt.push_back(mk(0, 32'h3004,     0,             0,     16'h0,    26'h0,     0, 0, 0, 0, 0,             1, 1, 0, M_HLD, 0));
        vt.push_back(mk(0, 32'h3004,     0,             0,     16'h0,    26'h0,     0, 0, 0, 0, 0,             0, 0, 0, M_HLD, 0));
        vt.push_back(mk(1, 32'h3004,     5,             5,     16'hFFFF, 26'h0C40,  1, 1, 1, 1, 32'h3020,      0, 1, 1, M_ABS, 32'h4180));
        vt.push_back(mk(1, 32'h3004,     5,             5,     16'hFFFF, 26'h0,     0, 0, 0, 1, 32'h3020,      0, 1, 1, M_ABS, 32'h3020));
        vt.push_back(mk(1, 32'h3004,     5,             5,     16'hFFFF, 26'h0C40,  1, 0, 0, 0, 0,             0, 1, 1, M_ABS, 32'h3004));
        vt.push_back(mk(0, 32'h3004,     32'h5550,      0,     16'h0,    26'h0C40,  1, 1, 0, 0, 0,             0, 1, 1, M_ABS, 32'h3100));
        vt.push_back(mk(0, 32'h3004,     32'hFFFFFFFC,  0,     16'h0,    26'h0,     0, 1, 0, 0, 0,             0, 1, 1, M_ABS, 32'hFFFFFFFC));
        vt.push_back(mk(0, 32'h3004,     0,             0,     16'h0,    26'h0,     0, 0, 0, 0, 0,             0, 1, 0, M_INC, 0));
        vt.push_back(mk(1, 32'hFFFFFFF8, 7,             7,     16'h0,    26'h0,     0, 0, 0, 0, 0,             0, 1, 1, M_ABS, 32'hFFFFFFFC));
        vt.push_back(mk(2, 32'h3004,     9,             9,     16'h0010, 26'h0,     0, 0, 0, 0, 0,             0, 1, 0, M_INC, 0));

        foreach (vt[i]) begin
            @(negedge clk);
            idle();
            br_op = vt[i].op; D_PC = vt[i].dpc; rs_val = vt[i].rs; rt_val = vt[i].rt;
            imm16 = vt[i].i16; imm26 = vt[i].i26; j_sign = vt[i].j; jr_sign = vt[i].jr;
            exc_req = vt[i].exc; eret_req = vt[i].eret; epc = vt[i].epc;
            stall = vt[i].stall; imem_ready = vt[i].rdy;
            #1;
            chk($sformatf("vec%0d redirect", i), 32'(redirect), 32'(vt[i].red));
            chk($sformatf("vec%0d D_PC8", i), D_PC8, vt[i].dpc + 32'd8);
            step();
            case (vt[i].mode)
                M_INC:   exp = model + 32'd4;
                M_HLD:   exp = model;
                default: exp = vt[i].nxt;
            endcase
            chk($sformatf("vec%0d F_PC", i), F_PC, exp);
            chk($sformatf("vec%0d pend_valid", i), 32'(pend_valid), 0);
            model = exp;
        end

        // Stalled beq waits, then redirects once stall drops.
        @(negedge clk);
        idle();
        br_op = 3'd1; rs_val = 5; rt_val = 5; imm16 = 16'hFFFF; stall = 1'b1;
        #1 chk("stall beq redirect", 32'(redirect), 0);
        step();
        chk("stall beq hold", F_PC, model);
        @(negedge clk);
        stall = 1'b0;
        #1 chk("unstall beq redirect", 32'(redirect), 1);
        step();
        chk("unstall beq F_PC", F_PC, 32'h3004);

        // Jump held in the pend latch across two not-ready cycles.
        @(negedge clk);
        idle();
        j_sign = 1'b1; imm26 = 26'h0000C40; imem_ready = 1'b0;
        #1 chk("pend j redirect", 32'(redirect), 1);
        step();
        chk("pend j valid1", 32'(pend_valid), 1);
        chk("pend j hold1", F_PC, 32'h3004);
        step();
        chk("pend j valid2", 32'(pend_valid), 1);
        chk("pend j hold2", F_PC, 32'h3004);
        @(negedge clk);
        j_sign = 1'b0; imem_ready = 1'b1;
        step();
        chk("pend j F_PC", F_PC, 32'h3100);
        chk("pend j cleared", 32'(pend_valid), 0);

        // A newer D jr must not displace the older pended jump.
        @(negedge clk);
        idle();
        j_sign = 1'b1; imm26 = 26'h0000D00; imem_ready = 1'b0;
        step();
        @(negedge clk);
        idle();
        jr_sign = 1'b1; rs_val = 32'h5550;
        step();
        chk("pend beats jr F_PC", F_PC, 32'h3400);
        chk("pend beats jr valid", 32'(pend_valid), 0);

        // Exception overrides a pend with memory ready, then eret returns.
        @(negedge clk);
        idle();
        j_sign = 1'b1; imm26 = 26'h0000100; imem_ready = 1'b0;
        step();
        chk("exc pend set", 32'(pend_valid), 1);
        @(negedge clk);
        idle();
        exc_req = 1'b1;
        step();
        chk("exc over pend F_PC", F_PC, 32'h4180);
        chk("exc over pend valid", 32'(pend_valid), 0);
        @(negedge clk);
        idle();
        eret_req = 1'b1; epc = 32'h3010;
        step();
        chk("eret F_PC", F_PC, 32'h3010);

        // Exception while not ready overwrites the pend latch.
        @(negedge clk);
        idle();
        j_sign = 1'b1; imm26 = 26'h0000C40; imem_ready = 1'b0;
        step();
        @(negedge clk);
        idle();
        exc_req = 1'b1; imem_ready = 1'b0;
        step();
        chk("exc pend hold", F_PC, 32'h3010);
        chk("exc pend valid", 32'(pend_valid), 1);
        @(negedge clk);
        idle();
        step();
        chk("exc pend F_PC", F_PC, 32'h4180);
        chk("exc pend cleared", 32'(pend_valid), 0);

        // Asynchronous reset in the middle of a pend.
        @(negedge clk);
        idle();
        j_sign = 1'b1; imm26 = 26'h0000C40; imem_ready = 1'b0;
        step();
        chk("mid pend set", 32'(pend_valid), 1);
        @(negedge clk);
        idle();
        exc_req = 1'b1; imem_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("async rst F_PC", F_PC, 32'h3000);
        chk("async rst pend", 32'(pend_valid), 0);
        chk("async rst redirect", 32'(redirect), 0);
        step();
        @(negedge clk);
        reset = 1'b0;
        idle();
        #1 chk("post rst F_PC", F_PC, 32'h3000);
        step();
        chk("post rst seq", F_PC, 32'h3004);
        chk("post rst pend", 32'(pend_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, meaning F_PC value after reset.
REQ-002 Parameter EXC_VEC, default 32'h0000_4180, meaning exception handler entry address.
REQ-003 Parameter PC_W, default 32, meaning width of every PC/address/operand port.
REQ-004 One clock; reset is asynchronous and active-high: clk  in  1  rising-edge clock; reset  in  1  async active-high reset.
REQ-005 stall  in  1  hazard stall from D; F_PC holds while high.
REQ-006 imem_ready  in  1  instruction memory accepted current F_PC.
REQ-007 D_PC  in  PC_W  PC of instruction in D.
REQ-008 br_op  in  3  0 none, 1 beq, 2 bne, 3 blez, 4 bgtz, 5 bltz, 6 bgez, 7 reserved (treated as none).
REQ-009 rs_val, rt_val  in  PC_W  forwarded D operands.
REQ-010 imm16  in  16  branch offset; imm26  in  26  jump index.
REQ-011 j_sign, jr_sign  in  1 each  direct / register jump in D (jal, jalr assert these).
REQ-012 exc_req  in  1  exception/interrupt taken this cycle; eret_req  in  1  eret in D; epc  in  PC_W  return address.
REQ-013 F_PC  out  PC_W  fetch address; D_PC8  out  PC_W  link value D_PC+8.
REQ-014 redirect  out  1  control transfer decided this cycle; pend_valid  out  1  redirect latched awaiting imem_ready.

Function
REQ-015 Target priority, highest first: exc_req -> EXC_VEC; eret_req -> epc; taken branch -> D_PC+4+(sext(imm16)<<2); j_sign -> {D_PC[PC_W-1:28],imm26,2'b00}; jr_sign -> rs_val; else sequential F_PC+4.
REQ-016 Branch compare signed, PC_W bits: beq rs==rt, bne rs!=rt, blez rs<=0, bgtz rs>0, bltz rs<0, bgez rs>=0.
REQ-017 redirect = exc_req, or (!stall and any of eret/taken branch/j/jr).
REQ-018 stall suppresses D-sourced redirects (D recomputes next cycle); exc_req and pend are never suppressed by stall.
REQ-019 F_PC update at clk: if redirect and imem_ready -> target; if redirect and !imem_ready -> latch target into pend register, set pend_valid, F_PC holds.
REQ-020 If pend_valid and imem_ready and no new exc_req -> F_PC <= pend, clear pend_valid; new exc_req overwrites pend with EXC_VEC.
REQ-021 D-sourced redirect while pend_valid is ignored (pended transfer is older); exc_req wins over pend.
REQ-022 Else if !stall and imem_ready and !pend_valid -> F_PC <= F_PC+4; otherwise F_PC holds.
REQ-023 All adds modulo 2^PC_W, wrap silently; F_PC+4 at 32'hFFFF_FFFC yields 0.
REQ-024 Latency: redirect decided in cycle N appears on F_PC in cycle N+1 when imem_ready, else first cycle after imem_ready rises.
REQ-025 D_PC8 purely combinational from D_PC.

Reset
REQ-026 reset asserted at any time, including mid-pend: F_PC = RESET_PC, pend = 0, pend_valid = 0, immediately and asynchronously.
REQ-027 redirect is 0 during reset regardless of inputs.

Structure
REQ-028 br_op encodings, RESET_PC and EXC_VEC defaults live in shared package cpu_pkg.
REQ-029 Combinational compare/target selection in sub-module pc_unit_tgt; pc_unit holds F_PC and pend registers only.

Verification
REQ-030 Reset release, stall=0, imem_ready=1, no ops: F_PC 3000,3004,3008 on successive cycles.
REQ-031 D_PC=3004, br_op=1, rs=rt=5, imm16=16'hFFFF: redirect=1, next F_PC=3004.
REQ-032 Same beq with stall=1: redirect=0, F_PC holds; stall drops next cycle -> F_PC=3004.
REQ-033 j_sign, imm26=26'h0000C40, imem_ready=0 two cycles: pend_valid=1, F_PC holds, then F_PC=3100 one cycle after imem_ready=1, pend_valid=0.
REQ-034 pend_valid=1 and exc_req=1, imem_ready=1: F_PC=4180; eret_req with epc=3010 later: F_PC=3010.
REQ-035 br_op=3 with rs=32'h8000_0000 taken, rs=1 not taken; reset asserted mid-pend -> F_PC=3000, pend_valid=0 same cycle.
